// File: rtl/hex_line_render_pkg.sv
// hex_line_render_pkg: glyph geometry, FSM states and band size shared by the renderer and its bench
package hex_line_render_pkg;
  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int band_pixels(input int nchars);
    return GLYPH_W * GLYPH_H * nchars;
  endfunction
endpackage

// File: rtl/hex_line_render_if.sv
// hex_line_render_if: load handshake, glyph ROM port and pixel stream of one hex text band
interface hex_line_render_if #(parameter int NCHARS = 8) ();
  logic                  load_valid;
  logic                  load_ready;
  logic [4*NCHARS-1:0]   load_data;
  logic                  cursor_en;
  logic [3:0]            cursor_idx;
  logic [3:0]            glyph_x;
  logic [3:0]            glyph_y;
  logic [3:0]            glyph_no;
  logic                  glyph_pixel;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix;
  logic                  pix_sol;
  logic                  pix_last;
  modport master (
    input  load_valid, load_data, cursor_en, cursor_idx, glyph_pixel, pix_ready,
    output load_ready, glyph_x, glyph_y, glyph_no, pix_valid, pix, pix_sol, pix_last
  );
  modport slave (
    output load_valid, load_data, cursor_en, cursor_idx, glyph_pixel, pix_ready,
    input  load_ready, glyph_x, glyph_y, glyph_no, pix_valid, pix, pix_sol, pix_last
  );
endinterface

// File: rtl/hex_line_render_glyph_scan_counter.sv
// glyph_scan_counter: nested column/digit/row raster counters for one band of glyphs
module glyph_scan_counter
  import hex_line_render_pkg::*;
#(parameter int NCHARS = 8) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       clear,
  output logic [3:0] column,
  output logic [3:0] digit,
  output logic [3:0] row,
  output logic       sol,
  output logic       last
);
  logic w_col_end, w_dig_end;
  assign w_col_end = column == 4'(GLYPH_W - 1);
  assign w_dig_end = digit == 4'(NCHARS - 1);
  assign sol       = column == 4'd0 && digit == 4'd0;
  assign last      = w_col_end && w_dig_end && row == 4'(GLYPH_H - 1);
  // The band never wraps rows: stepping past the final pixel parks at the origin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      column <= '0;
      digit  <= '0;
      row    <= '0;
    end else if (clear || (step && last)) begin
      column <= '0;
      digit  <= '0;
      row    <= '0;
    end else if (step) begin
      column <= column + 4'd1;
      if (w_col_end) begin
        digit <= w_dig_end ? 4'd0 : digit + 4'd1;
        row   <= w_dig_end ? row + 4'd1 : row;
      end
    end
  end
endmodule

// File: rtl/hex_line_render.sv
// hex_line_render: streams the glyph pixels of a band of hex digits in raster order
module hex_line_render
  import hex_line_render_pkg::*;
#(parameter int NCHARS = 8) (
  input logic clk,
  input logic reset_n,
  hex_line_render_if.master bus
);
  state_t              r_state, w_state_nx;
  logic [4*NCHARS-1:0] r_data;
  logic                r_cursor_en;
  logic [3:0]          r_cursor_idx;
  logic                r_primed, r_load_ready, r_pix_valid, r_pix, r_pix_sol, r_pix_last;
  logic                w_load, w_adv, w_drained, w_ready_nx, w_sol, w_last;
  logic [3:0]          w_col, w_dig, w_row, w_glyph_no;

  glyph_scan_counter #(.NCHARS(NCHARS)) u_scan (
    .clk(clk), .reset_n(reset_n), .step(w_adv), .clear(r_state == IDLE),
    .column(w_col), .digit(w_dig), .row(w_row), .sol(w_sol), .last(w_last)
  );

  assign w_load    = r_state == IDLE && r_load_ready && bus.load_valid;
  // The first RUN cycle lets the ROM address settle on the freshly captured word
  assign w_adv     = r_state == RUN && r_primed && (!r_pix_valid || bus.pix_ready);
  assign w_drained = r_state == DRAIN && r_pix_valid && bus.pix_ready;

  always_comb begin
    w_glyph_no = '0;
    for (int i = 0; i < NCHARS; i++)
      if (w_dig == 4'(i)) w_glyph_no = r_data[4*(NCHARS-1-i) +: 4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_load_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_load_ready <= w_ready_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ready_nx = r_load_ready;
    case (r_state)
      IDLE: begin
        w_state_nx = w_load ? RUN : IDLE;
        w_ready_nx = !w_load;
      end
      RUN:   w_state_nx = (w_adv && w_last) ? DRAIN : RUN;
      DRAIN: begin
        w_state_nx = w_drained ? IDLE : DRAIN;
        w_ready_nx = w_drained;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data       <= '0;
      r_cursor_en  <= 1'b0;
      r_cursor_idx <= '0;
      r_primed     <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix        <= 1'b0;
      r_pix_sol    <= 1'b0;
      r_pix_last   <= 1'b0;
    end else begin
      r_primed <= r_state == RUN;
      if (w_load) begin
        r_data       <= bus.load_data;
        r_cursor_en  <= bus.cursor_en;
        r_cursor_idx <= bus.cursor_idx;
      end
      if (w_adv) begin
        r_pix       <= bus.glyph_pixel ^ (r_cursor_en && w_dig == r_cursor_idx);
        r_pix_valid <= 1'b1;
        r_pix_sol   <= w_sol;
        r_pix_last  <= w_last;
      end else if (w_drained) begin
        r_pix       <= 1'b0;
        r_pix_valid <= 1'b0;
        r_pix_sol   <= 1'b0;
        r_pix_last  <= 1'b0;
      end
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.glyph_x    = w_col;
  assign bus.glyph_y    = w_row;
  assign bus.glyph_no   = w_glyph_no;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix        = r_pix;
  assign bus.pix_sol    = r_pix_sol;
  assign bus.pix_last   = r_pix_last;
endmodule

// File: tb/tb_hex_line_render.sv
// tb_hex_line_render: table and random bands checked against a raster model and a ROM model
module tb_hex_line_render;
  import hex_line_render_pkg::*;
  localparam int N  = 8;
  localparam int NP = band_pixels(N);

  typedef struct {
    logic [4*N-1:0] data;
    bit             cen;
    logic [3:0]     cidx;
    int             stall;
    int             row;
    int             dig;
    logic [15:0]    seg;
    string          name;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hex_line_render_if #(.NCHARS(N)) bus();
  hex_line_render #(.NCHARS(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [15:0] font [16][16];
  always_comb bus.glyph_pixel = font[bus.glyph_no][bus.glyph_y][4'hF - bus.glyph_x];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit got_pix [NP];
  bit got_sol [NP];
  bit got_last [NP];
  int got_n, k_edge, first_valid_cyc, last_acc_edge, unstable;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mpix(input logic [4*N-1:0] d, input bit cen, input logic [3:0] cidx, input int p);
    int row = p / (GLYPH_W * N);
    int dig = (p / GLYPH_W) % N;
    int col = p % GLYPH_W;
    logic [3:0] nib = 4'(d >> (4 * (N - 1 - dig)));
    logic [15:0] line = font[nib][row];
    return line[15 - col] ^ (cen && dig == int'(cidx));
  endfunction

  task automatic run_band(input logic [4*N-1:0] d, input bit cen, input logic [3:0] cidx,
                          input int stall_pct, input int abort_at);
    int guard = 0;
    bit prev_stall = 0;
    logic [2:0] prev = '0;
    got_n = 0; unstable = 0; first_valid_cyc = -1; last_acc_edge = -1;
    @(negedge clk);
    while (!bus.load_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("load_ready before load", bus.load_ready, 1);
    bus.load_data = d; bus.cursor_en = cen; bus.cursor_idx = cidx;
    bus.load_valid = 1'b1; bus.pix_ready = 1'b1;
    k_edge = cyc + 1;
    @(negedge clk);
    bus.load_valid = 1'b0; bus.load_data = $urandom; bus.cursor_en = !cen; bus.cursor_idx = 4'($urandom_range(15));
    guard = 0;
    while (guard < 3 * NP) begin
      if (prev_stall && {bus.pix_valid, bus.pix, bus.pix_sol, bus.pix_last} !== {1'b1, prev}) unstable++;
      if (bus.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      bus.pix_ready = $urandom_range(99) >= stall_pct;
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev = {bus.pix, bus.pix_sol, bus.pix_last};
      if (bus.pix_valid && bus.pix_ready) begin
        if (got_n < NP) begin
          got_pix[got_n] = bus.pix; got_sol[got_n] = bus.pix_sol; got_last[got_n] = bus.pix_last;
        end
        got_n++;
        if (bus.pix_last) begin
          last_acc_edge = cyc + 1;
          break;
        end
      end
      if (abort_at >= 0 && got_n == abort_at) break;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic check_band(input string tag, input logic [4*N-1:0] d, input bit cen,
                            input logic [3:0] cidx, input bit timed);
    int bp = 0, bs = 0, bl = 0, fp = -1;
    chk($sformatf("%s pixel count", tag), got_n, NP);
    for (int p = 0; p < NP; p++) begin
      if (got_pix[p] !== mpix(d, cen, cidx, p)) begin
        bp++;
        if (fp < 0) fp = p;
      end
      if (got_sol[p] !== (p % (GLYPH_W * N) == 0)) bs++;
      if (got_last[p] !== (p == NP - 1)) bl++;
    end
    chk($sformatf("%s pixel errors first@%0d", tag, fp), bp, 0);
    chk($sformatf("%s sol errors", tag), bs, 0);
    chk($sformatf("%s last errors", tag), bl, 0);
    chk($sformatf("%s stall stability violations", tag), unstable, 0);
    chk($sformatf("%s first pixel latency", tag), 64'(first_valid_cyc - k_edge), 2);
    if (timed) chk($sformatf("%s band length", tag), 64'(last_acc_edge - k_edge), NP + 2);
    else chk($sformatf("%s band ended", tag), last_acc_edge >= 0, 1);
    if (last_acc_edge >= 0) begin
      while (cyc < last_acc_edge + 1) @(negedge clk);
      chk($sformatf("%s idle after band", tag), {bus.pix_valid, bus.load_ready}, 2'b01);
    end
  endtask

  vec_t vecs [8];

  initial begin
    for (int g = 0; g < 16; g++)
      for (int r = 0; r < 16; r++)
        font[g][r] = (g == 0 && r == 0) ? 16'h0 : 16'($urandom);
    font[0][1] = 16'b0000001111100000;
    font[1][1] = 16'b0000000110000000;
    font[3][1] = 16'b0000011111000000;
    vecs[0] = '{32'h0000_0000, 0, 4'd0, 0, 0, 0, 16'h0000, "zero row0 d0"};
    vecs[1] = '{32'h0000_0000, 0, 4'd0, 30, 1, 0, 16'b0000001111100000, "zero row1 d0"};
    vecs[2] = '{32'h1234_5678, 0, 4'd0, 0, 1, 0, 16'b0000000110000000, "glyph1 row1"};
    vecs[3] = '{32'h1234_5678, 0, 4'd0, 30, 1, 2, 16'b0000011111000000, "glyph3 row1"};
    vecs[4] = '{32'h0000_0000, 1, 4'd2, 0, 0, 2, 16'hFFFF, "cursor2 inverted"};
    vecs[5] = '{32'h0000_0000, 1, 4'd2, 30, 0, 1, 16'h0000, "cursor2 neighbour"};
    vecs[6] = '{32'h0000_0000, 1, 4'd9, 0, 0, 2, 16'h0000, "cursor9 none"};
    vecs[7] = '{32'h0000_0000, 1, 4'd7, 30, 0, 7, 16'hFFFF, "cursor7 last digit"};

    bus.load_valid = 1'b0; bus.load_data = '0; bus.cursor_en = 1'b0; bus.cursor_idx = '0; bus.pix_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("outputs in reset", {bus.load_ready, bus.pix_valid, bus.pix, bus.pix_sol, bus.pix_last,
                               bus.glyph_x, bus.glyph_y, bus.glyph_no}, 0);
    end
    reset_n = 1'b1;
    #1 chk("load_ready before first edge", bus.load_ready, 0);
    @(negedge clk);
    chk("load_ready after first edge", bus.load_ready, 1);

    foreach (vecs[i]) begin
      logic [15:0] seg;
      run_band(vecs[i].data, vecs[i].cen, vecs[i].cidx, vecs[i].stall, -1);
      for (int c = 0; c < 16; c++)
        seg[15 - c] = got_pix[vecs[i].row * GLYPH_W * N + vecs[i].dig * GLYPH_W + c];
      chk($sformatf("%s segment", vecs[i].name), seg, vecs[i].seg);
      check_band(vecs[i].name, vecs[i].data, vecs[i].cen, vecs[i].cidx, vecs[i].stall == 0);
    end

    for (int i = 0; i < 4; i++) begin
      logic [4*N-1:0] d = $urandom;
      bit cen = 1'($urandom_range(1));
      logic [3:0] cidx = 4'($urandom_range(15));
      int st = (i == 0) ? 0 : 30;
      run_band(d, cen, cidx, st, -1);
      check_band($sformatf("random%0d", i), d, cen, cidx, st == 0);
    end

    run_band(32'hFEDC_BA98, 1, 4'd3, 30, 700);
    reset_n = 1'b0;
    #1 chk("outputs on mid-band reset", {bus.load_ready, bus.pix_valid, bus.pix, bus.pix_sol, bus.pix_last,
                                         bus.glyph_x, bus.glyph_y, bus.glyph_no}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("glyph origin after reset", {bus.glyph_x, bus.glyph_y, bus.glyph_no, bus.load_ready}, 13'h1);
    run_band(32'h9ABC_DEF0, 1, 4'd4, 0, -1);
    check_band("after reset", 32'h9ABC_DEF0, 1, 4'd4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
